// File: rtl/reg_bus_xfer_ctrl.sv
// reg_bus_xfer_ctrl
// Sequences src->dst register moves over the shared tri-state register bus.
// Two requesters (A = fetch/decode, B = execute) are arbitrated round-robin.
// A normal move drives the source for one settle cycle (DRIVE) before the
// write cycle (WRITE). src == dst and out-of-range indices complete in a
// single NOP cycle with no enables.
// All outputs are registered and decoded from the next state, so no
// combinational path exists from the request inputs to any output.
// Optional feature macro: WF8_BUS_TURNAROUND_EN inserts a one-cycle TURN
// state (all enables low) after every WRITE/NOP.
module reg_bus_xfer_ctrl #(
    parameter int REG_COUNT = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [ADDR_W-1:0]    a_src,
    input  logic [ADDR_W-1:0]    a_dst,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADDR_W-1:0]    b_src,
    input  logic [ADDR_W-1:0]    b_dst,
    output logic                 b_ready,
    output logic [REG_COUNT-1:0] out_en,
    output logic [REG_COUNT-1:0] write_en,
    output logic                 busy,
    output logic                 grant_b,
    output logic                 idx_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WRITE = 3'd2,
        NOP   = 3'd3,
        TURN  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // last_grant: 0 = A, 1 = B. Resets to B so A wins the first tie.
    logic last_grant_reg, last_grant_next;
    logic grant_b_reg, grant_b_next;
    logic [ADDR_W-1:0] src_reg, src_next;
    logic [ADDR_W-1:0] dst_reg, dst_next;

    logic [REG_COUNT-1:0] out_en_reg, out_en_next;
    logic [REG_COUNT-1:0] write_en_reg, write_en_next;
    logic a_ready_reg, a_ready_next;
    logic b_ready_reg, b_ready_next;
    logic busy_reg, busy_next;
    logic idx_err_reg, idx_err_next;

    // Arbitration helpers (only meaningful while IDLE)
    logic              pick_b;
    logic [ADDR_W-1:0] req_src;
    logic [ADDR_W-1:0] req_dst;
    logic              req_bad;
    logic              drive_next;
    logic              write_next;

    // Round-robin pick: a lone request wins; on a tie the requester not granted last wins.
    always_comb begin
        pick_b  = b_valid && (!a_valid || !last_grant_reg);
        req_src = pick_b ? b_src : a_src;
        req_dst = pick_b ? b_dst : a_dst;
        req_bad = (int'(req_src) >= REG_COUNT) || (int'(req_dst) >= REG_COUNT);
    end

    // Next-state logic; the move is captured into src/dst registers at grant.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_b_next    = grant_b_reg;
        src_next        = src_reg;
        dst_next        = dst_reg;
        idx_err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (a_valid || b_valid) begin
                    last_grant_next = pick_b;
                    grant_b_next    = pick_b;
                    src_next        = req_src;
                    dst_next        = req_dst;
                    if (req_bad) begin
                        state_next   = NOP;
                        idx_err_next = 1'b1;
                    end else if (req_src == req_dst) begin
                        state_next = NOP;
                    end else begin
                        state_next = DRIVE;
                    end
                end
            end
            DRIVE: state_next = WRITE;
            WRITE, NOP: begin
`ifdef WF8_BUS_TURNAROUND_EN
                state_next = TURN;
`else
                state_next = IDLE;
`endif
            end
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        drive_next   = (state_next == DRIVE) || (state_next == WRITE);
        write_next   = (state_next == WRITE);
        a_ready_next = ((state_next == WRITE) || (state_next == NOP)) && !grant_b_next;
        b_ready_next = ((state_next == WRITE) || (state_next == NOP)) && grant_b_next;
        busy_next    = (state_next != IDLE);
    end

    // One-hot enable decode per bus register
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_en
            assign out_en_next[gi]   = drive_next && (src_next == ADDR_W'(gi));
            assign write_en_next[gi] = write_next && (dst_next == ADDR_W'(gi));
        end
    endgenerate

    // State and captured-move registers; reset discards any move in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_b_reg    <= 1'b0;
            src_reg        <= '0;
            dst_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_b_reg    <= grant_b_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
        end
    end

    // Registered outputs; enables drop immediately on reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_reg   <= '0;
            write_en_reg <= '0;
            a_ready_reg  <= 1'b0;
            b_ready_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            idx_err_reg  <= 1'b0;
        end else begin
            out_en_reg   <= out_en_next;
            write_en_reg <= write_en_next;
            a_ready_reg  <= a_ready_next;
            b_ready_reg  <= b_ready_next;
            busy_reg     <= busy_next;
            idx_err_reg  <= idx_err_next;
        end
    end

    assign out_en   = out_en_reg;
    assign write_en = write_en_reg;
    assign a_ready  = a_ready_reg;
    assign b_ready  = b_ready_reg;
    assign busy     = busy_reg;
    assign grant_b  = grant_b_reg;
    assign idx_err  = idx_err_reg;

endmodule

// File: tb/tb_reg_bus_xfer_ctrl.sv
// Testbench for reg_bus_xfer_ctrl: directed steps with a completion scoreboard.
// Honours WF8_BUS_TURNAROUND_EN for the expected move period and TURN cycle.
module tb_reg_bus_xfer_ctrl;

`ifdef WF8_BUS_TURNAROUND_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance, REG_COUNT = 4
    logic       a_valid = 0, b_valid = 0;
    logic [1:0] a_src = 0, a_dst = 0, b_src = 0, b_dst = 0;
    logic       a_ready, b_ready, busy, grant_b, idx_err;
    logic [3:0] out_en, write_en;

    // Second instance, REG_COUNT = 3, for out-of-range indices
    logic       x_a_valid = 0, x_b_valid = 0;
    logic [1:0] x_a_src = 0, x_a_dst = 0, x_b_src = 0, x_b_dst = 0;
    logic       x_a_ready, x_b_ready, x_busy, x_grant_b, x_idx_err;
    logic [2:0] x_out_en, x_write_en;

    reg_bus_xfer_ctrl #(.REG_COUNT(4), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_src(a_src), .a_dst(a_dst), .a_ready(a_ready),
        .b_valid(b_valid), .b_src(b_src), .b_dst(b_dst), .b_ready(b_ready),
        .out_en(out_en), .write_en(write_en), .busy(busy),
        .grant_b(grant_b), .idx_err(idx_err)
    );

    reg_bus_xfer_ctrl #(.REG_COUNT(3), .ADDR_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(x_a_valid), .a_src(x_a_src), .a_dst(x_a_dst), .a_ready(x_a_ready),
        .b_valid(x_b_valid), .b_src(x_b_src), .b_dst(x_b_dst), .b_ready(x_b_ready),
        .out_en(x_out_en), .write_en(x_write_en), .busy(x_busy),
        .grant_b(x_grant_b), .idx_err(x_idx_err)
    );

    typedef struct {
        bit         is_b;
        logic [3:0] oe;
        logic [3:0] we;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_b, input logic [3:0] oe, input logic [3:0] we, input logic err);
        exp_t e;
        e.is_b = is_b;
        e.oe   = oe;
        e.we   = we;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a ready pulse on the main instance, sampled at negedge.
    task automatic wait_ready(input string tag, output bit ga, output bit gb);
        ga = 1'b0;
        gb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                ga = a_ready;
                gb = b_ready;
                break;
            end
        end
        chk({tag, "_ready_seen"}, {31'b0, ga | gb}, 32'd1);
    endtask

    // Per-cycle invariants and scoreboard pop on completion
    exp_t mon_e;
    always @(negedge clk) begin
        chk("inv_onehot0_out_en", {31'b0, $onehot0(out_en)}, 32'd1);
        chk("inv_onehot0_write_en", {31'b0, $onehot0(write_en)}, 32'd1);
        chk("inv_one_ready", {31'b0, a_ready && b_ready}, 32'd0);
        chk("inv_we_needs_other_oe",
            {31'b0, (write_en == 4'd0) || (out_en != 4'd0 && out_en != write_en)}, 32'd1);
        chk("inv3_onehot0_write_en", {31'b0, $onehot0(x_write_en)}, 32'd1);
        chk("inv3_onehot0_out_en", {31'b0, $onehot0(x_out_en)}, 32'd1);
        if (a_ready || b_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("txn: req=%s out_en=%b write_en=%b idx_err=%0b cyc=%0d",
                         b_ready ? "B" : "A", out_en, write_en, idx_err, cyc);
                chk("sb_requester", {31'b0, b_ready}, {31'b0, mon_e.is_b});
                chk("sb_grant_b", {31'b0, grant_b}, {31'b0, mon_e.is_b});
                chk("sb_out_en", {28'b0, out_en}, {28'b0, mon_e.oe});
                chk("sb_write_en", {28'b0, write_en}, {28'b0, mon_e.we});
                chk("sb_idx_err", {31'b0, idx_err}, {31'b0, mon_e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ga, gb;
        int t1, t2, t3;

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_out_en", {28'b0, out_en}, 32'd0);
        chk("reset_write_en", {28'b0, write_en}, 32'd0);
        chk("reset_flags", {27'b0, busy, a_ready, b_ready, grant_b, idx_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: basic move 1 -> 2, latency and enables per cycle
        @(posedge clk); #1;
        a_valid = 1; a_src = 2'd1; a_dst = 2'd2;
        push(1'b0, 4'b0010, 4'b0100, 1'b0);
        @(negedge clk);
        chk("t1_c0_out_en", {28'b0, out_en}, 32'd0);
        @(negedge clk);
        chk("t1_c1_out_en", {28'b0, out_en}, 32'h2);
        chk("t1_c1_write_en", {28'b0, write_en}, 32'd0);
        chk("t1_c1_a_ready", {31'b0, a_ready}, 32'd0);
        chk("t1_c1_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_c2_out_en", {28'b0, out_en}, 32'h2);
        chk("t1_c2_write_en", {28'b0, write_en}, 32'h4);
        chk("t1_c2_a_ready", {31'b0, a_ready}, 32'd1);
        @(posedge clk); #1;
        a_valid = 0;
        @(negedge clk);
`ifdef WF8_BUS_TURNAROUND_EN
        chk("t1_turn_busy", {31'b0, busy}, 32'd1);
        chk("t1_turn_enables", {24'b0, out_en, write_en}, 32'd0);
        @(negedge clk);
`endif
        chk("t1_c3_busy", {31'b0, busy}, 32'd0);

        // 2: tie right after reset -> A, B, A, B
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_valid = 1; a_src = 2'd0; a_dst = 2'd1;
        b_valid = 1; b_src = 2'd2; b_dst = 2'd3;
        push(1'b0, 4'b0001, 4'b0010, 1'b0);
        push(1'b1, 4'b0100, 4'b1000, 1'b0);
        push(1'b0, 4'b1000, 4'b0001, 1'b0);
        push(1'b1, 4'b0010, 4'b0001, 1'b0);
        wait_ready("t2_first", ga, gb);
        chk("t2_first_is_a", {31'b0, ga}, 32'd1);
        @(posedge clk); #1;
        a_src = 2'd3; a_dst = 2'd0;
        wait_ready("t2_second", ga, gb);
        chk("t2_second_is_b", {31'b0, gb}, 32'd1);
        @(posedge clk); #1;
        b_src = 2'd1; b_dst = 2'd0;
        wait_ready("t2_third", ga, gb);
        chk("t2_third_is_a", {31'b0, ga}, 32'd1);
        @(posedge clk); #1;
        a_valid = 0;
        wait_ready("t2_fourth", ga, gb);
        chk("t2_fourth_is_b", {31'b0, gb}, 32'd1);
        @(posedge clk); #1;
        b_valid = 0;

        // 3: src == dst on B -> NOP, ready one cycle after grant
        repeat (3) @(posedge clk);
        #1;
        b_valid = 1; b_src = 2'd3; b_dst = 2'd3;
        push(1'b1, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("t3_c0_b_ready", {31'b0, b_ready}, 32'd0);
        @(negedge clk);
        chk("t3_c1_b_ready", {31'b0, b_ready}, 32'd1);
        chk("t3_c1_enables", {24'b0, out_en, write_en}, 32'd0);
        chk("t3_c1_idx_err", {31'b0, idx_err}, 32'd0);
        @(posedge clk); #1;
        b_valid = 0;

        // 4: REG_COUNT = 3, dst = 3 -> NOP with idx_err
        repeat (3) @(posedge clk);
        #1;
        x_a_valid = 1; x_a_src = 2'd0; x_a_dst = 2'd3;
        @(negedge clk);
        chk("t4_c0_a_ready", {31'b0, x_a_ready}, 32'd0);
        @(negedge clk);
        $display("txn: dut3 req=A ready=%0b idx_err=%0b write_en=%b", x_a_ready, x_idx_err, x_write_en);
        chk("t4_a_ready", {31'b0, x_a_ready}, 32'd1);
        chk("t4_idx_err", {31'b0, x_idx_err}, 32'd1);
        chk("t4_write_en", {29'b0, x_write_en}, 32'd0);
        chk("t4_out_en", {29'b0, x_out_en}, 32'd0);
        @(posedge clk); #1;
        x_a_valid = 0;
        @(negedge clk);
        chk("t4_idx_err_pulse", {31'b0, x_idx_err}, 32'd0);

        // 5: reset during DRIVE discards the move
        repeat (3) @(posedge clk);
        #1;
        a_valid = 1; a_src = 2'd2; a_dst = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_drive_out_en", {28'b0, out_en}, 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_out_en", {28'b0, out_en}, 32'd0);
        chk("t5_async_busy", {31'b0, busy}, 32'd0);
        a_valid = 0;
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_ready", {30'b0, a_ready, b_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_valid = 1; a_src = 2'd2; a_dst = 2'd0;
        push(1'b0, 4'b0100, 4'b0001, 1'b0);
        wait_ready("t5_reissue", ga, gb);
        chk("t5_reissue_is_a", {31'b0, ga}, 32'd1);
        @(posedge clk); #1;
        a_valid = 0;

        // 6: continuous A moves, ready period
        repeat (3) @(posedge clk);
        #1;
        a_valid = 1; a_src = 2'd3; a_dst = 2'd1;
        repeat (3) push(1'b0, 4'b1000, 4'b0010, 1'b0);
        wait_ready("t6_r1", ga, gb);
        t1 = cyc;
`ifdef WF8_BUS_TURNAROUND_EN
        @(negedge clk);
        chk("t6_turn_enables", {24'b0, out_en, write_en}, 32'd0);
        chk("t6_turn_busy", {31'b0, busy}, 32'd1);
`endif
        wait_ready("t6_r2", ga, gb);
        t2 = cyc;
        chk("t6_period_1", t2 - t1, PERIOD);
        wait_ready("t6_r3", ga, gb);
        t3 = cyc;
        chk("t6_period_2", t3 - t2, PERIOD);
        @(posedge clk); #1;
        a_valid = 0;

        repeat (4) @(negedge clk);
        chk("end_idle", {31'b0, busy}, 32'd0);
        chk("end_sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
